i2s_rx: RTL and testbench

//  I2S receiver for the card's ADC (ADC_DOUT). Captures stereo frames on the shared BCK/LRCK that the i2s transmitter drives to the DAC.

---
 rtl/audio_pkg.sv | 12 +
 rtl/i2s_rx_if.sv | 31 +++
 rtl/audio_frame_fifo.sv | 54 +++++
 rtl/i2s_rx.sv | 155 +++++++++++++++
 tb/tb_i2s_rx.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared audio constants and the stereo frame type used by the i2s tx/rx and the sound path.
package audio_pkg;

  localparam int AUDIO_SAMPLE_W = 16;
  localparam int AUDIO_SLOT_W   = 32;

  typedef struct packed {
    logic [AUDIO_SAMPLE_W-1:0] left;
    logic [AUDIO_SAMPLE_W-1:0] right;
  } audio_frame_t;

endpackage

// File: rtl/i2s_rx_if.sv
// Record-side bus of the I2S receiver: live samples plus the show-ahead frame FIFO read port.
interface i2s_rx_if #(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 8
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [SAMPLE_W-1:0] sample_l;
  logic [SAMPLE_W-1:0] sample_r;
  logic                sample_valid;
  logic                fifo_rd;
  logic [SAMPLE_W-1:0] fifo_l;
  logic [SAMPLE_W-1:0] fifo_r;
  logic                fifo_empty;
  logic                fifo_full;
  logic [LVL_W-1:0]    fifo_level;

  modport master (
    output sample_l, sample_r, sample_valid,
    output fifo_l, fifo_r, fifo_empty, fifo_full, fifo_level,
    input  fifo_rd
  );

  modport slave (
    input  sample_l, sample_r, sample_valid,
    input  fifo_l, fifo_r, fifo_empty, fifo_full, fifo_level,
    output fifo_rd
  );

endinterface

// File: rtl/audio_frame_fifo.sv
// Synchronous show-ahead FIFO of stereo frames; a pop in the same cycle as a push to a full FIFO frees the slot first.
module audio_frame_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH = 2 * AUDIO_SAMPLE_W,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == LVL_W'(DEPTH));
  assign level   = level_reg;
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  // Head is read combinationally so the consumer sees data without a request cycle.
  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push_ok && !pop_ok)      level_reg <= level_reg + LVL_W'(1);
      else if (pop_ok && !push_ok) level_reg <= level_reg - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wr_data;
  end

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: captures stereo frames from ADC_DOUT on the shared BCK/LRCK and queues them for record.
// Define I2S_RX_OVF_CNT_EN to build the saturating dropped-frame counter behind ovf_count.
module i2s_rx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = AUDIO_SAMPLE_W,
  parameter int SLOT_W     = AUDIO_SLOT_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       sclk,
  input  logic       lrclk,
  input  logic       sdata,
  i2s_rx_if.master   rec,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic [7:0] ovf_count
);

  localparam int CNT_W = $clog2(SLOT_W + 1);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                sclk_d_reg;
  logic                lr_prev_reg;
  logic                synced_reg;
  logic                left_ok_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [SAMPLE_W-1:0] word_reg;
  logic [SAMPLE_W-1:0] word_next;
  logic [SAMPLE_W-1:0] left_hold_reg;
  logic [SAMPLE_W-1:0] sample_l_reg;
  logic [SAMPLE_W-1:0] sample_r_reg;
  logic                sample_valid_reg;
  logic                overflow_reg;

  logic                rise;
  logic                cap;
  logic                boundary;
  logic                commit_l;
  logic                commit_r;
  logic                push;
  logic                drop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [2*SAMPLE_W-1:0] fifo_head;
  logic [LVL_W-1:0]    fifo_level;

  assign rise     = sclk & ~sclk_d_reg;
  assign cap      = rise & en;
  assign boundary = cap & (lrclk != lr_prev_reg);
  assign commit_l = boundary & synced_reg & ~lr_prev_reg;
  assign commit_r = boundary & synced_reg & lr_prev_reg;
  assign push     = commit_r & left_ok_reg;
  // With the FIFO full, a simultaneous pop makes room, so only a pop-less push is lost.
  assign drop     = push & fifo_full & ~rec.fifo_rd;

  // Bit cnt lands at position SAMPLE_W-1-cnt; counts past the kept width match nothing.
  for (genvar gi = 0; gi < SAMPLE_W; gi++) begin : g_bit
    assign word_next[gi] = (cnt_reg == CNT_W'(SAMPLE_W - 1 - gi)) ? sdata : word_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_d_reg       <= 1'b0;
      lr_prev_reg      <= 1'b0;
      synced_reg       <= 1'b0;
      left_ok_reg      <= 1'b0;
      cnt_reg          <= '0;
      word_reg         <= '0;
      left_hold_reg    <= '0;
      sample_l_reg     <= '0;
      sample_r_reg     <= '0;
      sample_valid_reg <= 1'b0;
      overflow_reg     <= 1'b0;
    end else begin
      sclk_d_reg       <= sclk;
      sample_valid_reg <= push;
      if (!en) begin
        synced_reg  <= 1'b0;
        left_ok_reg <= 1'b0;
        cnt_reg     <= '0;
        word_reg    <= '0;
      end else if (cap) begin
        lr_prev_reg <= lrclk;
        if (boundary) begin
          word_reg   <= '0;
          cnt_reg    <= '0;
          synced_reg <= 1'b1;
          if (commit_l) begin
            left_hold_reg <= word_next;
            left_ok_reg   <= 1'b1;
          end
          if (commit_r) begin
            left_ok_reg <= 1'b0;
            if (left_ok_reg) begin
              sample_l_reg <= left_hold_reg;
              sample_r_reg <= word_next;
            end
          end
        end else begin
          word_reg <= word_next;
          if (cnt_reg != CNT_W'(SLOT_W)) cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
      if (drop)         overflow_reg <= 1'b1;
      else if (ovf_clr) overflow_reg <= 1'b0;
    end
  end

  audio_frame_fifo #(
    .WIDTH (2 * SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data ({left_hold_reg, word_next}),
    .pop     (rec.fifo_rd),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  assign rec.sample_l     = sample_l_reg;
  assign rec.sample_r     = sample_r_reg;
  assign rec.sample_valid = sample_valid_reg;
  assign rec.fifo_l       = fifo_head[2*SAMPLE_W-1:SAMPLE_W];
  assign rec.fifo_r       = fifo_head[SAMPLE_W-1:0];
  assign rec.fifo_empty   = fifo_empty;
  assign rec.fifo_full    = fifo_full;
  assign rec.fifo_level   = fifo_level;
  assign overflow         = overflow_reg;

`ifdef I2S_RX_OVF_CNT_EN
  logic [7:0] ovf_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_cnt_reg <= 8'h00;
    end else if (ovf_clr) begin
      ovf_cnt_reg <= drop ? 8'h01 : 8'h00;
    end else if (drop && ovf_cnt_reg != 8'hFF) begin
      ovf_cnt_reg <= ovf_cnt_reg + 8'h01;
    end
  end

  assign ovf_count = ovf_cnt_reg;
`else
  assign ovf_count = 8'h00;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: an I2S transmitter model drives slot streams; a slot-level model predicts frames and FIFO state.
module tb_i2s_rx;
  import audio_pkg::*;

  localparam int SW    = 16;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       sclk = 1'b0;
  logic       lrclk = 1'b0;
  logic       sdata = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       overflow;
  logic [7:0] ovf_count;

  i2s_rx_if #(.SAMPLE_W(SW), .FIFO_DEPTH(DEPTH)) rec ();

  i2s_rx #(.SAMPLE_W(SW), .SLOT_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sclk      (sclk),
    .lrclk     (lrclk),
    .sdata     (sdata),
    .rec       (rec),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  int           n_vec = 0;
  int           n_err = 0;
  audio_frame_t exp_samples[$];
  audio_frame_t exp_fifo[$];
  bit           exp_ovf = 1'b0;
  int           exp_ovf_cnt = 0;
  bit           m_last_ch = 1'b0;
  bit           m_started = 1'b0;
  bit           m_have_left = 1'b0;
  logic [15:0]  m_left = '0;
  bit           m_slot_ch = 1'b0;
  logic [15:0]  m_slot_word = '0;
  bit           tx_last_bit = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] rnd40();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[39:0];
  endfunction

  // Kept sample: first 16 transmitted bits of the slot, zero-filled when the slot is shorter.
  function automatic logic [15:0] slot_word(input logic [39:0] d, input int len);
    logic [15:0] top;
    top = d[39:24];
    if (len >= 16) return top;
    return (top >> (16 - len)) << (16 - len);
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef I2S_RX_OVF_CNT_EN
    return 32'(exp_ovf_cnt);
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_level"}, 32'(rec.fifo_level), 32'(exp_fifo.size()));
    chk({tag, "_empty"}, 32'(rec.fifo_empty), 32'(exp_fifo.size() == 0));
    chk({tag, "_full"}, 32'(rec.fifo_full), 32'(exp_fifo.size() == DEPTH));
    chk({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, "_ovf_count"}, 32'(ovf_count), exp_cnt());
    if (exp_fifo.size() > 0) chk({tag, "_head"}, {rec.fifo_l, rec.fifo_r}, exp_fifo[0]);
  endtask

  // One bit clock: low for two clk cycles, then high; the DUT sees the rise on the next posedge.
  task automatic bck(input bit lr, input bit b, input bit pop, input bit clr);
    @(negedge clk);
    sclk = 1'b0; lrclk = lr; sdata = b;
    @(negedge clk);
    @(negedge clk);
    sclk = 1'b1; rec.fifo_rd = pop; ovf_clr = clr;
    @(negedge clk);
    rec.fifo_rd = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic fifo_step(input bit pop, input bit push, input audio_frame_t f, input bit clr);
    bit drop = 1'b0;
    if (pop && exp_fifo.size() > 0) begin
      chk("pop_head", {rec.fifo_l, rec.fifo_r}, exp_fifo[0]);
      void'(exp_fifo.pop_front());
    end
    if (push) begin
      if (exp_fifo.size() < DEPTH) exp_fifo.push_back(f);
      else drop = 1'b1;
    end
    if (clr) begin exp_ovf = 1'b0; exp_ovf_cnt = 0; end
    if (drop) begin
      exp_ovf = 1'b1;
      if (exp_ovf_cnt < 255) exp_ovf_cnt++;
    end
  endtask

  task automatic pop_check();
    @(negedge clk);
    if (exp_fifo.size() > 0) chk("pop_head", {rec.fifo_l, rec.fifo_r}, exp_fifo[0]);
    rec.fifo_rd = 1'b1;
    @(negedge clk);
    rec.fifo_rd = 1'b0;
    if (exp_fifo.size() > 0) void'(exp_fifo.pop_front());
  endtask

  task automatic clear_ovf();
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    exp_ovf = 1'b0; exp_ovf_cnt = 0;
  endtask

  task automatic en_gap(input bit ch);
    @(negedge clk);
    en = 1'b0;
    m_started = 1'b0; m_have_left = 1'b0;
    pop_check();
    bck(ch, 1'($urandom), 1'b0, 1'b0);
    bck(ch, 1'($urandom), 1'b0, 1'b0);
    check_state("en_off");
    @(negedge clk);
    en = 1'b1;
  endtask

  // One channel slot; its first bit clock carries the last bit of the previous slot.
  task automatic send_slot(input bit ch, input logic [39:0] d, input int len,
                           input bit pop0 = 1'b0, input bit clr0 = 1'b0, input int gap_at = -1);
    bit           b;
    bit           push;
    audio_frame_t f;
    for (int j = 0; j < len; j++) begin
      if (j == gap_at) en_gap(ch);
      b = (j == 0) ? tx_last_bit : d[40 - j];
      if (j == 0) begin
        push = 1'b0;
        f = '0;
        if (en && ch != m_last_ch) begin
          if (m_started) begin
            if (m_slot_ch == 1'b0) begin
              m_left = m_slot_word; m_have_left = 1'b1;
            end else begin
              if (m_have_left) begin push = 1'b1; f = {m_left, m_slot_word}; end
              m_have_left = 1'b0;
            end
          end
          m_started = 1'b1;
        end
        if (en) m_last_ch = ch;
        if (push) exp_samples.push_back(f);
        fifo_step(pop0, push, f, clr0);
      end
      bck(ch, b, (j == 0) && pop0, (j == 0) && clr0);
    end
    m_slot_ch = ch;
    m_slot_word = slot_word(d, len);
    tx_last_bit = d[40 - len];
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; en = 1'b0; sclk = 1'b0;
    repeat (3) @(negedge clk);
    chk("valid_pending", 32'(exp_samples.size()), 32'd0);
    exp_samples.delete();
    exp_fifo.delete();
    exp_ovf = 1'b0; exp_ovf_cnt = 0;
    m_last_ch = 1'b0; m_started = 1'b0; m_have_left = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every sample_valid pulse consumes exactly one expected frame.
  initial begin
    audio_frame_t f;
    forever begin
      @(negedge clk);
      if (!reset && rec.sample_valid) begin
        if (exp_samples.size() == 0) begin
          chk("spurious_valid", 32'd1, 32'd0);
        end else begin
          f = exp_samples.pop_front();
          chk("sample_lr", {rec.sample_l, rec.sample_r}, f);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [39:0]  d;
    audio_frame_t nxt;
    int           n0;
    int           len;
    bit           ch;
    rec.fifo_rd = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_sample", {rec.sample_l, rec.sample_r}, 32'd0);
    chk("rst_valid", 32'(rec.sample_valid), 32'd0);
    chk("rst_empty", 32'(rec.fifo_empty), 32'd1);
    chk("rst_full", 32'(rec.fifo_full), 32'd0);
    chk("rst_level", 32'(rec.fifo_level), 32'd0);
    chk("rst_ovf", {23'd0, overflow, ovf_count}, 32'd0);
    do_reset();

    // Basic frame A55A / 1234 after a discarded lead-in partial slot
    en = 1'b1;
    send_slot(1'b1, rnd40(), 10);
    send_slot(1'b0, {16'hA55A, 24'($urandom)}, 32);
    send_slot(1'b1, {16'h1234, 24'($urandom)}, 32);
    send_slot(1'b0, rnd40(), 32);
    chk("t1_sample", {rec.sample_l, rec.sample_r}, 32'hA55A1234);
    chk("t1_head", {rec.fifo_l, rec.fifo_r}, 32'hA55A1234);
    check_state("t1");

    // Reset in the middle of a right slot, then resume mid-slot
    send_slot(1'b1, rnd40(), 12);
    do_reset();
    check_state("t2_rst");
    en = 1'b1;
    send_slot(1'b1, rnd40(), 20);
    d = rnd40();
    send_slot(1'b0, d, 32);
    nxt.left = d[39:24];
    d = rnd40();
    send_slot(1'b1, d, 32);
    nxt.right = d[39:24];
    send_slot(1'b0, rnd40(), 32);
    chk("t2_first_frame", {rec.fifo_l, rec.fifo_r}, nxt);
    check_state("t2");

    // Fill to eight frames, then one more is dropped
    for (int i = 1; i <= 8; i++) begin
      send_slot(1'b1, rnd40(), 32);
      send_slot(1'b0, rnd40(), 32);
      if (i == 7) chk("t3_full", 32'(rec.fifo_full), 32'd1);
      check_state("t3");
    end
    chk("t3_level", 32'(rec.fifo_level), 32'd8);
    chk("t3_ovf", 32'(overflow), 32'd1);
    clear_ovf();
    check_state("t3_clr");

    // Full FIFO with a pop in the push cycle
    nxt = exp_fifo[1];
    send_slot(1'b1, rnd40(), 32);
    send_slot(1'b0, rnd40(), 32, 1'b1);
    chk("t4_level", 32'(rec.fifo_level), 32'd8);
    chk("t4_head", {rec.fifo_l, rec.fifo_r}, nxt);
    chk("t4_ovf", 32'(overflow), 32'd0);
    check_state("t4");

    // Clear coincident with a drop: the drop wins
    send_slot(1'b1, rnd40(), 32);
    send_slot(1'b0, rnd40(), 32, 1'b0, 1'b1);
    chk("t4_clr_drop", 32'(overflow), 32'd1);
    check_state("t4b");
    clear_ovf();

    // Drain, pop on empty, then short and long slots
    repeat (DEPTH) pop_check();
    pop_check();
    check_state("t5_empty");
    send_slot(1'b1, rnd40(), 32);
    send_slot(1'b0, {8'hC3, 32'($urandom)}, 8);
    d = rnd40();
    send_slot(1'b1, d, 40);
    send_slot(1'b0, rnd40(), 32);
    chk("t5_short_l", 32'(rec.sample_l), 32'h0000C300);
    chk("t5_long_r", 32'(rec.sample_r), 32'(d[39:24]));
    check_state("t5");

    // Enable dropped mid left slot
    send_slot(1'b1, rnd40(), 32);
    send_slot(1'b0, rnd40(), 32, 1'b0, 1'b0, 10);
    n0 = exp_fifo.size();
    send_slot(1'b1, rnd40(), 32);
    send_slot(1'b0, rnd40(), 32);
    chk("t6_no_frame", 32'(rec.fifo_level), 32'(n0));
    send_slot(1'b1, rnd40(), 32);
    send_slot(1'b0, rnd40(), 32);
    chk("t6_resume", 32'(rec.fifo_level), 32'(n0 + 1));
    check_state("t6");

    // Randomised slot lengths, pops and clears
    for (int k = 0; k < 40; k++) begin
      ch = (k % 2 == 0);
      len = $urandom_range(40, 8);
      send_slot(ch, rnd40(), len, ($urandom_range(2) == 0), ($urandom_range(7) == 0));
      if ($urandom_range(3) == 0) pop_check();
      check_state("t7");
    end

    repeat (4) @(negedge clk);
    chk("valid_missing", 32'(exp_samples.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
